// File: rtl/aes_ti_pkg.sv
// Shared definitions for the masked AES S-box datapath.
// Contents:
//   GF24_POLY : GF(2^4) modulus x^4+x+1
//   RW_DEF    : default width of fresh randomness per accepted nibble
//   nib2_t    : 2-share nibble, [0] = share 0, [1] = share 1
//   INV_TBL   : GF(2^4) inverse table, used as a reference model by benches
//   gf16_mul / gf16_sq : polynomial-basis GF(2^4) arithmetic
package aes_ti_pkg;

  localparam logic [4:0] GF24_POLY = 5'b10011;
  localparam int         RW_DEF    = 8;

  typedef logic [1:0][3:0] nib2_t;

  // Entry [k] is k^-1, with 0 mapped to 0.
  localparam logic [15:0][3:0] INV_TBL = {
    4'h8, 4'h3, 4'h4, 4'hA, 4'h5, 4'hC, 4'h2, 4'hF,
    4'h6, 4'h7, 4'hB, 4'hD, 4'hE, 4'h9, 4'h1, 4'h0
  };

  // Shift-and-add multiply with reduction by x^4+x+1.
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] aa;
    p  = 4'h0;
    aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[2:0], 1'b0} ^ (aa[3] ? GF24_POLY[3:0] : 4'h0);
    end
    return p;
  endfunction

  // Squaring is linear over GF(2), so it may be applied to each share alone.
  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    return gf16_mul(a, a);
  endfunction

endpackage

// File: rtl/gf24_mul_share_term.sv
// One cross-share product term of a domain-oriented masked GF(2^4) multiply.
// Ports:
//   a_i : one share of operand a
//   b_i : one share of operand b
//   m_i : refresh mask (fresh randomness for cross-domain terms, 0 otherwise)
//   y_o : a_i * b_i ^ m_i
// Each instance sees exactly one share of each operand; shares are only
// recombined after the result has been registered by the parent.
module gf24_mul_share_term
  import aes_ti_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] m_i,
  output logic [3:0] y_o
);

  assign y_o = gf16_mul(a_i, b_i) ^ m_i;

endmodule

// File: rtl/gf24_inv_ti_pipe.sv
// Pipelined 2-share masked GF(2^4) inverter, 3 register stages.
// Ports:
//   CLK, RSTn        : clock, synchronous active-low reset
//   in_vld / in_rdy  : input handshake for in0/in1/rnd
//   in0, in1         : shares of operand x (polynomial basis mod x^4+x+1)
//   rnd              : fresh randomness, sampled only on an accepted input
//   out_vld / out_rdy: output handshake for out0/out1
//   out0, out1       : shares of x^-1
//   busy             : any stage holds valid data
// x^-1 = x^14 = x^2 * x^4 * x^8. The three powers are linear, so they are
// computed share-wise; the two products are masked multiplies:
//   S1: registers a_i*b_j terms (a=x^2, b=x^4), cross terms refreshed with
//       rnd[3:0]; also carries c=x^8 shares and rnd[7:4] forward.
//   S2: recombines S1 into shares of p=a*b, registers p_i*c_j terms, cross
//       terms refreshed with the carried rnd[7:4].
//   S3: recombines S2 into the output shares.
module gf24_inv_ti_pipe
  import aes_ti_pkg::*;
#(
  parameter int RW  = RW_DEF,
  parameter int LAT = 3
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [3:0]    in0,
  input  logic [3:0]    in1,
  input  logic [RW-1:0] rnd,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [3:0]    out0,
  output logic [3:0]    out1,
  output logic          busy
);

  if (LAT != 3 || RW < 8) begin : g_param_chk
    $error("gf24_inv_ti_pipe: LAT must be 3 and RW at least 8");
  end

  logic v1_q, v2_q, v3_q;
  logic en1, en2, en3;

  nib2_t x_sh, a_sh, b_sh, c_sh, p_sh;
  nib2_t c_q, o_d, o_q;
  logic [3:0][3:0] t_d, t_q, u_d, u_q;
  logic [3:0] r2_q;

  // A stage may advance when it is empty or its successor advances.
  assign en3     = !v3_q | out_rdy;
  assign en2     = !v2_q | en3;
  assign en1     = !v1_q | en2;
  assign in_rdy  = en1;
  assign out_vld = v3_q;
  assign busy    = v1_q | v2_q | v3_q;
  assign out0    = o_q[0];
  assign out1    = o_q[1];

  assign x_sh = {in1, in0};

  for (genvar i = 0; i < 2; i++) begin : g_lin
    assign a_sh[i] = gf16_sq(x_sh[i]);
    assign b_sh[i] = gf16_sq(a_sh[i]);
    assign c_sh[i] = gf16_sq(b_sh[i]);
  end

  // Term index k = 2*i + j: share i of the first operand, share j of the
  // second. Domain 0 owns terms 0,1 and domain 1 owns terms 3,2.
  assign p_sh[0] = t_q[0] ^ t_q[1];
  assign p_sh[1] = t_q[3] ^ t_q[2];
  assign o_d[0]  = u_q[0] ^ u_q[1];
  assign o_d[1]  = u_q[3] ^ u_q[2];

  for (genvar i = 0; i < 2; i++) begin : g_row
    for (genvar j = 0; j < 2; j++) begin : g_col
      localparam bit CROSS = (i != j);
      gf24_mul_share_term u_s1 (
        .a_i (a_sh[i]),
        .b_i (b_sh[j]),
        .m_i (CROSS ? rnd[3:0] : 4'h0),
        .y_o (t_d[2*i+j])
      );
      gf24_mul_share_term u_s2 (
        .a_i (p_sh[i]),
        .b_i (c_q[j]),
        .m_i (CROSS ? r2_q : 4'h0),
        .y_o (u_d[2*i+j])
      );
    end
  end

  // Data registers only load when a valid item moves in, so rnd is taken
  // exclusively on accepted transfers and idle bubbles do not toggle shares.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      t_q  <= '0;
      c_q  <= '0;
      r2_q <= '0;
      u_q  <= '0;
      o_q  <= '0;
    end else begin
      if (en1) v1_q <= in_vld;
      if (en1 && in_vld) begin
        t_q  <= t_d;
        c_q  <= c_sh;
        r2_q <= rnd[7:4];
      end
      if (en2) v2_q <= v1_q;
      if (en2 && v1_q) u_q <= u_d;
      if (en3) v3_q <= v2_q;
      if (en3 && v2_q) o_q <= o_d;
    end
  end

endmodule
